// File: rtl/mskaes_ctrl_pkg.sv
// Shared types and constants for the masked AES-128 control path:
// FSM state encoding, round-constant parameters and the GF(2^8) xtime helper.
package mskaes_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } ctrl_state_e;

  localparam logic [7:0] RCON_INIT    = 8'h01;
  localparam logic [7:0] RCON_POLY    = 8'h1B;
  localparam int         SBOX_LAT_DEF = 4;
  localparam int         NROUNDS_DEF  = 10;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mskaes_rcon_gen.sv
// AES round-constant register: loads RCON_INIT or advances by xtime once per round.
// Shared between the round scheduler and the key-schedule side.
module mskaes_rcon_gen
  import mskaes_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       adv_i,
  output logic [7:0] rcon_o
);

  logic [7:0] rcon_q, rcon_d;

  // NOTE: next-state is defaulted to the held value first so always_comb cannot infer a latch.
  always_comb begin
    rcon_d = rcon_q;
    if (load_i) begin
      rcon_d = RCON_INIT;
    end else if (adv_i) begin
      rcon_d = xtime(rcon_q);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcon_q <= RCON_INIT;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon_o = rcon_q;

endmodule

// File: rtl/mskaes_round_scheduler.sv
// Round sequencer for the masked AES-128 core: walks the shared S-box/linear datapath
// through NROUNDS rounds and drives per-cycle enables, rcon and the result handshake.
module mskaes_round_scheduler
  import mskaes_ctrl_pkg::*;
#(
  parameter int d        = 2,
  parameter int SBOX_LAT = SBOX_LAT_DEF,
  parameter int NROUNDS  = NROUNDS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       state_ld,
  output logic       sb_start,
  output logic       rnd_en,
  output logic       state_en,
  output logic       key_en,
  output logic       mc_bypass,
  output logic [7:0] rcon,
  output logic [3:0] round_idx,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int                CYC_W      = $clog2(SBOX_LAT + 1);
  localparam logic [CYC_W-1:0]  CYC_LAST   = CYC_W'(SBOX_LAT);
  localparam logic [3:0]        ROUND_LAST = 4'(NROUNDS);

  if (d < 1 || SBOX_LAT < 1 || NROUNDS < 1 || NROUNDS > 15) begin : g_bad_param
    $error("mskaes_round_scheduler: illegal parameter combination");
  end

  ctrl_state_e      state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [3:0]       round_q, round_d;
  logic             rcon_load, rcon_adv;
  logic             accept;

  // Flush masks the handshake so a pending load can never slip in during an abort.
  assign in_ready = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign state_ld = accept;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    round_d   = round_q;
    rcon_load = 1'b0;
    rcon_adv  = 1'b0;
    if (flush) begin
      state_d   = ST_IDLE;
      cyc_d     = '0;
      round_d   = '0;
      rcon_load = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d   = ST_ROUND;
            cyc_d     = '0;
            round_d   = 4'd1;
            rcon_load = 1'b1;
          end
        end
        ST_ROUND: begin
          if (cyc_q == CYC_LAST) begin
            cyc_d = '0;
            if (round_q < ROUND_LAST) begin
              round_d  = round_q + 4'd1;
              rcon_adv = 1'b1;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            cyc_d     = '0;
            rcon_load = 1'b1;
            if (in_valid) begin
              state_d = ST_ROUND;
              round_d = 4'd1;
            end else begin
              state_d = ST_IDLE;
              round_d = '0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cyc_d   = '0;
          round_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from next-state so they are registered yet aligned with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      round_q   <= '0;
      sb_start  <= 1'b0;
      rnd_en    <= 1'b0;
      state_en  <= 1'b0;
      key_en    <= 1'b0;
      mc_bypass <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      round_q   <= round_d;
      sb_start  <= (state_d == ST_ROUND) && (cyc_d == '0);
      rnd_en    <= (state_d == ST_ROUND) && (cyc_d < CYC_LAST);
      state_en  <= (state_d == ST_ROUND) && (cyc_d == CYC_LAST);
      key_en    <= (state_d == ST_ROUND) && (cyc_d == CYC_LAST);
      mc_bypass <= (state_d == ST_ROUND) && (round_d == ROUND_LAST);
      busy      <= (state_d != ST_IDLE);
      out_valid <= (state_d == ST_DONE);
    end
  end

  assign round_idx = round_q;

  mskaes_rcon_gen u_rcon_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (rcon_load),
    .adv_i  (rcon_adv),
    .rcon_o (rcon)
  );

endmodule

// File: tb/tb_mskaes_round_scheduler.sv
// Bench for mskaes_round_scheduler: two instances (SBOX_LAT=4 and SBOX_LAT=1) checked every
// cycle against an elapsed-cycle model, plus directed latency/flush/reset scenarios.
module tb_mskaes_round_scheduler;

  localparam int NR = 10;
  localparam logic [7:0] RCON_TAB [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  typedef struct packed {
    logic       in_ready;
    logic       state_ld;
    logic       sb_start;
    logic       rnd_en;
    logic       state_en;
    logic       key_en;
    logic       mc_bypass;
    logic [7:0] rcon;
    logic [3:0] round_idx;
    logic       busy;
    logic       out_valid;
  } obs_t;

  typedef enum int {M_IDLE, M_RUN, M_DONE} mmode_e;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic iv [2];
  logic ory [2];
  logic fl [2];
  logic in_ready_w [2];
  logic state_ld_w [2];
  logic sb_start_w [2];
  logic rnd_en_w [2];
  logic state_en_w [2];
  logic key_en_w [2];
  logic mc_bypass_w [2];
  logic busy_w [2];
  logic out_valid_w [2];
  logic [7:0] rcon_w [2];
  logic [3:0] round_w [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;
  mmode_e m_mode [2];
  int m_k [2];

  int r_lat, r_sb, r_se, r_rnd, r_byp, r_first_sb, r_first_se, r_last_se, r_first_byp;
  logic [7:0] r_rc9, r_rc10;

  always #5 clk = ~clk;

  mskaes_round_scheduler #(.d(2), .SBOX_LAT(4), .NROUNDS(NR)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(fl[0]), .in_valid(iv[0]), .in_ready(in_ready_w[0]),
    .state_ld(state_ld_w[0]), .sb_start(sb_start_w[0]), .rnd_en(rnd_en_w[0]),
    .state_en(state_en_w[0]), .key_en(key_en_w[0]), .mc_bypass(mc_bypass_w[0]),
    .rcon(rcon_w[0]), .round_idx(round_w[0]), .busy(busy_w[0]), .out_valid(out_valid_w[0]),
    .out_ready(ory[0])
  );

  mskaes_round_scheduler #(.d(2), .SBOX_LAT(1), .NROUNDS(NR)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(fl[1]), .in_valid(iv[1]), .in_ready(in_ready_w[1]),
    .state_ld(state_ld_w[1]), .sb_start(sb_start_w[1]), .rnd_en(rnd_en_w[1]),
    .state_en(state_en_w[1]), .key_en(key_en_w[1]), .mc_bypass(mc_bypass_w[1]),
    .rcon(rcon_w[1]), .round_idx(round_w[1]), .busy(busy_w[1]), .out_valid(out_valid_w[1]),
    .out_ready(ory[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic obs_t obs_of(input int i);
    obs_t s;
    s.in_ready  = in_ready_w[i];
    s.state_ld  = state_ld_w[i];
    s.sb_start  = sb_start_w[i];
    s.rnd_en    = rnd_en_w[i];
    s.state_en  = state_en_w[i];
    s.key_en    = key_en_w[i];
    s.mc_bypass = mc_bypass_w[i];
    s.rcon      = rcon_w[i];
    s.round_idx = round_w[i];
    s.busy      = busy_w[i];
    s.out_valid = out_valid_w[i];
    return s;
  endfunction

  function automatic bit model_ready(input int i);
    return !fl[i] && (m_mode[i] == M_IDLE || (m_mode[i] == M_DONE && ory[i]));
  endfunction

  // Expected outputs from cycles elapsed since accept: k=1 is the first ROUND cycle.
  function automatic obs_t expect_obs(input int i);
    obs_t e;
    int l, r, p;
    e = '0;
    e.rcon = 8'h01;
    l = lat_of(i);
    if (m_mode[i] == M_RUN) begin
      r = (m_k[i] - 1) / (l + 1) + 1;
      p = (m_k[i] - 1) % (l + 1);
      e.sb_start  = (p == 0);
      e.rnd_en    = (p < l);
      e.state_en  = (p == l);
      e.key_en    = (p == l);
      e.mc_bypass = (r == NR);
      e.round_idx = 4'(r);
      e.rcon      = RCON_TAB[r];
      e.busy      = 1'b1;
    end else if (m_mode[i] == M_DONE) begin
      e.round_idx = 4'(NR);
      e.rcon      = RCON_TAB[NR];
      e.busy      = 1'b1;
      e.out_valid = 1'b1;
    end
    e.in_ready = model_ready(i);
    e.state_ld = iv[i] && e.in_ready;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] <= M_IDLE;
        m_k[i]    <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fl[i]) begin
          m_mode[i] <= M_IDLE;
        end else if (iv[i] && model_ready(i)) begin
          m_mode[i] <= M_RUN;
          m_k[i]    <= 1;
        end else if (m_mode[i] == M_RUN) begin
          if (m_k[i] == NR * (lat_of(i) + 1)) m_mode[i] <= M_DONE;
          else m_k[i] <= m_k[i] + 1;
        end else if (m_mode[i] == M_DONE && ory[i]) begin
          m_mode[i] <= M_IDLE;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("cycle_dut%0d", i), 32'(obs_of(i)), 32'(expect_obs(i)));
      end
    end
  end

  // Caller raises in_valid in the accept cycle; this waits for the result and profiles it.
  task automatic measure(input int i, input int budget);
    obs_t s;
    r_lat = -1; r_sb = 0; r_se = 0; r_rnd = 0; r_byp = 0;
    r_first_sb = -1; r_first_se = -1; r_last_se = -1; r_first_byp = -1;
    r_rc9 = 8'h00; r_rc10 = 8'h00;
    step();
    iv[i]  = 1'b0;
    ory[i] = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      s = obs_of(i);
      if (s.sb_start) begin
        r_sb++;
        if (r_first_sb < 0) r_first_sb = k;
        if (s.round_idx == 4'd9) r_rc9 = s.rcon;
        if (s.round_idx == 4'd10) r_rc10 = s.rcon;
      end
      if (s.state_en) begin
        r_se++;
        if (r_first_se < 0) r_first_se = k;
        r_last_se = k;
      end
      if (s.rnd_en) r_rnd++;
      if (s.mc_bypass) begin
        r_byp++;
        if (r_first_byp < 0) r_first_byp = k;
      end
      if (s.out_valid) begin
        r_lat = k;
        break;
      end
    end
  endtask

  initial begin
    obs_t s;
    obs_t rst_exp;
    int ov_cnt;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ory[i] = 1'b0; fl[i] = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    @(negedge clk);
    s = obs_of(0);
    check("reset_in_ready", 32'(s.in_ready), 32'd1);
    check("reset_rcon", 32'(s.rcon), 32'h01);
    check("reset_round_idx", 32'(s.round_idx), 32'd0);
    check("reset_busy", 32'(s.busy), 32'd0);

    // Single block with default latency.
    step();
    iv[0] = 1'b1;
    measure(0, 80);
    check("blk_latency", 32'(r_lat), 32'd51);
    check("blk_sb_pulses", 32'(r_sb), 32'd10);
    check("blk_first_sb", 32'(r_first_sb), 32'd1);
    check("blk_state_en_pulses", 32'(r_se), 32'd10);
    check("blk_first_state_en", 32'(r_first_se), 32'd5);
    check("blk_last_state_en", 32'(r_last_se), 32'd50);
    check("blk_rnd_en_cycles", 32'(r_rnd), 32'd40);
    check("blk_first_bypass", 32'(r_first_byp), 32'd46);
    check("blk_bypass_cycles", 32'(r_byp), 32'd5);
    check("blk_rcon_round9", 32'(r_rc9), 32'h1B);
    check("blk_rcon_round10", 32'(r_rc10), 32'h36);

    // Result held under back-pressure, then released together with a new load.
    repeat (7) step();
    @(negedge clk);
    s = obs_of(0);
    check("hold_out_valid", 32'(s.out_valid), 32'd1);
    check("hold_rcon", 32'(s.rcon), 32'h36);
    check("hold_mc_bypass", 32'(s.mc_bypass), 32'd0);
    step();
    ory[0] = 1'b1;
    iv[0]  = 1'b1;
    @(negedge clk);
    s = obs_of(0);
    check("b2b_state_ld", 32'(s.state_ld), 32'd1);
    measure(0, 80);
    check("b2b_first_sb", 32'(r_first_sb), 32'd1);
    check("b2b_latency", 32'(r_lat), 32'd51);

    // SBOX_LAT=1 instance.
    step();
    iv[1] = 1'b1;
    measure(1, 60);
    check("lat1_latency", 32'(r_lat), 32'd21);
    check("lat1_rnd_en_cycles", 32'(r_rnd), 32'd10);
    check("lat1_state_en_pulses", 32'(r_se), 32'd10);
    check("lat1_first_state_en", 32'(r_first_se), 32'd2);
    check("lat1_last_state_en", 32'(r_last_se), 32'd20);
    step();
    ory[1] = 1'b1;
    step();
    ory[1] = 1'b0;

    // Flush in the middle of round 5.
    ory[0] = 1'b1;
    step();
    ory[0] = 1'b0;
    iv[0]  = 1'b1;
    step();
    iv[0] = 1'b0;
    repeat (22) step();
    fl[0] = 1'b1;
    @(negedge clk);
    s = obs_of(0);
    check("flush_in_ready_masked", 32'(s.in_ready), 32'd0);
    step();
    fl[0] = 1'b0;
    @(negedge clk);
    s = obs_of(0);
    check("flush_idle_in_ready", 32'(s.in_ready), 32'd1);
    check("flush_no_out_valid", 32'(s.out_valid), 32'd0);
    check("flush_round_idx", 32'(s.round_idx), 32'd0);
    check("flush_busy", 32'(s.busy), 32'd0);
    step();
    iv[0] = 1'b1;
    measure(0, 80);
    check("post_flush_latency", 32'(r_lat), 32'd51);

    // Asynchronous reset between clock edges mid-computation.
    ory[0] = 1'b1;
    step();
    ory[0] = 1'b0;
    iv[0]  = 1'b1;
    step();
    iv[0] = 1'b0;
    repeat (29) step();
    #2 rst_n = 1'b0;
    #1;
    rst_exp = '0;
    rst_exp.in_ready = 1'b1;
    rst_exp.rcon = 8'h01;
    check("async_reset_outputs", 32'(obs_of(0)), 32'(rst_exp));
    repeat (2) step();
    rst_n = 1'b1;
    ov_cnt = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (out_valid_w[0]) ov_cnt++;
    end
    check("post_reset_no_out_valid", 32'(ov_cnt), 32'd0);

    // Randomized traffic on both instances, checked every cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        iv[i]  = ($urandom_range(0, 2) == 0);
        ory[i] = ($urandom_range(0, 1) == 1);
        fl[i]  = ($urandom_range(0, 63) == 0);
      end
    end
    step();
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ory[i] = 1'b0; fl[i] = 1'b0;
    end
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got t=%0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mskaes_round_scheduler.md
# mskaes_round_scheduler

Control sequencer for the masked AES-128 encryption core. It accepts a load request, then walks the shared datapath (DOM S-box pipeline followed by ShiftRows/MixColumns/AddRoundKey over all `d` shares) through 10 rounds. It generates per-cycle enables, the MixColumns bypass for the final round, the round constant for the key schedule, and the output handshake. It holds no share data; it only drives control signals into the datapath and key schedule.

## Interface
- `d`, default 2: number of shares; passed through for width checks only, no effect on timing.
- `SBOX_LAT`, default 4: DOM S-box pipeline depth in cycles; ≥1.
- `NROUNDS`, default 10: AES rounds.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `flush` in 1: synchronous abort, returns to IDLE.
- `in_valid` in 1: load request (shares of plaintext and key are valid on the datapath inputs).
- `in_ready` out 1: load accepted when `in_valid & in_ready`.
- `state_ld` out 1: state/key registers load the input shares (ARK0 path).
- `sb_start` out 1: first S-box pipeline cycle of a round.
- `rnd_en` out 1: DOM fresh-randomness consumption enable.
- `state_en` out 1: state register captures the SR/MC/ARK result.
- `key_en` out 1: key schedule advances one round.
- `mc_bypass` out 1: MixColumns skipped (final round).
- `rcon` out 8: round constant for the current round.
- `round_idx` out 4: current round, 1..NROUNDS; 0 when idle.
- `busy` out 1: a computation is in flight.
- `out_valid` out 1: ciphertext shares are valid on the state register.
- `out_ready` in 1: consumer takes the result.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE: `in_ready=1`. On accept, go to ROUND with `round_idx=1`, `cyc=0`, `rcon=0x01`.
- `state_ld = in_valid & in_ready` (combinational). Asserted in the accept cycle only.
- ROUND uses cycle counter `cyc` in 0..SBOX_LAT:
  - `sb_start=1` when `cyc==0`.
  - `rnd_en=1` when `cyc<SBOX_LAT`.
  - `state_en=key_en=1` when `cyc==SBOX_LAT`.
- At `cyc==SBOX_LAT`:
  - If `round_idx<NROUNDS`: increment `round_idx`, `rcon<=xtime(rcon)`, `cyc<=0`.
  - Else go to DONE.
- `mc_bypass=1` whenever `round_idx==NROUNDS` and the FSM is in ROUND.
- xtime rule: `(rcon<<1) ^ (rcon[7] ? 0x1B : 0)`, truncated to 8 bits. Round 9 gives 0x1B and round 10 gives 0x36.
- DONE: `out_valid=1`, held stable until `out_ready`. `round_idx`, `rcon` and `mc_bypass` stay at their final values, with `mc_bypass=0` in DONE.
- `in_ready = IDLE | (DONE & out_ready)`. Output taken together with `in_valid` means back-to-back: DONE→ROUND directly, and `state_ld` fires in the same cycle.
- Output taken without `in_valid`: DONE→IDLE, `round_idx=0`.
- `busy = (state != IDLE)`.
- `flush` has priority over every transition:
  - Next state IDLE, counters cleared, no `out_valid`.
  - `in_ready` forced to 0 in the flush cycle.
  - A pending `in_valid` is not accepted.
- `in_valid` while in ROUND is ignored. No stall inside ROUND: the datapath is never back-pressured mid-computation.

## Timing
- Reset values (during and after `rst_n=0`):
  - State IDLE, `in_ready=1`, `rcon=0x01`.
  - All other outputs 0, `round_idx=0`, `cyc=0`.
- Reset asserted mid-computation aborts immediately and asynchronously. No partial `out_valid`.
- Accept at cycle T. Round r occupies cycles T+1+(SBOX_LAT+1)(r−1) .. T+(SBOX_LAT+1)r.
- Last `state_en` at T+NROUNDS·(SBOX_LAT+1), which is T+50 with defaults.
- `out_valid` first high at T+51 (defaults). Accept-to-result latency is 51 cycles.
- Back-to-back throughput is one block per 51 cycles when `out_ready` and `in_valid` are held high.
- Exactly NROUNDS pulses each of `sb_start`, `state_en`, `key_en` per block. Exactly NROUNDS·SBOX_LAT `rnd_en` cycles per block.
- All outputs are registered except `in_ready` and `state_ld`.

## Structure
- Package `mskaes_ctrl_pkg` contains:
  - State enum (IDLE/ROUND/DONE).
  - `RCON_INIT=8'h01`, `RCON_POLY=8'h1B`.
  - `xtime` function.
  - Default constants for `SBOX_LAT` and `NROUNDS`.
- One sub-module, `mskaes_rcon_gen`: an 8-bit rcon register with load-init and xtime-advance enable. It is reused by the key-schedule side.

## Test plan
- Reset, then single block: `in_valid` pulse at T.
  - `state_ld` at T only.
  - `sb_start` at T+1, T+6, …, T+46; `state_en` at T+5, …, T+50.
  - `mc_bypass` high T+46..T+50; `out_valid` at T+51.
- rcon trace across rounds 1..10 equals 01,02,04,08,10,20,40,80,1B,36.
- `out_ready` low for 7 cycles after T+51: `out_valid` stays high and signals are stable. Release with `in_valid` high: same-cycle accept, next `sb_start` one cycle later.
- `flush` asserted at T+23: IDLE at T+24, `in_ready=1`, no `out_valid`, `round_idx=0`. A fresh block then completes with latency 51.
- `rst_n` dropped at T+30 between clock edges: outputs reach their reset values without waiting for a clock edge. After release, no `out_valid` appears until a new accept.
- `SBOX_LAT=1`: `state_en` every 2 cycles, `out_valid` at T+21, 10 `rnd_en` cycles.
